// File: rtl/reg_file_pkg.sv
// Shared defaults and write-port-select encoding for the scoreboarded register file.
// Port B (load return) outranks port A (writeback) whenever both target one index.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        WSEL_NONE = 2'd0,
        WSEL_A    = 2'd1,
        WSEL_B    = 2'd2
    } wsel_e;

    function automatic wsel_e wsel_pick(input logic hit_a, input logic hit_b);
        if (hit_b) begin
            return WSEL_B;
        end else if (hit_a) begin
            return WSEL_A;
        end
        return WSEL_NONE;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared by writeback
// or flush, with a combinational population count of the registered bits.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ZERO_R0 = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen_a,
    input  logic [ADDR_W-1:0]   wn_a,
    input  logic                wen_b,
    input  logic [ADDR_W-1:0]   wn_b,
    input  logic                sb_set,
    input  logic [ADDR_W-1:0]   sb_addr,
    input  logic                sb_flush,
    output logic [2**ADDR_W-1:0] pend,
    output logic [ADDR_W:0]     pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_set;
    logic [DEPTH-1:0] w_clr;
    logic [ADDR_W:0]  w_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            if (ZERO_R0 != 0 && gi == 0) begin : g_zero
                assign w_set[gi] = 1'b0;
            end else begin : g_live
                assign w_set[gi] = sb_set && (sb_addr == ADDR_W'(gi));
            end
            assign w_clr[gi] = (wen_a && (wn_a == ADDR_W'(gi))) ||
                               (wen_b && (wn_b == ADDR_W'(gi)));
        end
    endgenerate

    // A new issue in the same cycle as a writeback keeps the bit: set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else if (sb_flush) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_set | (r_pend & ~w_clr);
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_cnt = w_cnt + (ADDR_W+1)'(r_pend[i]);
        end
    end

    assign pend     = r_pend;
    assign pend_cnt = w_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Two-read, two-write register file with optional hardwired r0, same-cycle write
// forwarding, and a pending-write scoreboard driving per-read-port busy flags.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rn1,
    input  logic [ADDR_W-1:0] rn2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              wen_a,
    input  logic [ADDR_W-1:0] wn_a,
    input  logic [DATA_W-1:0] wd_a,
    input  logic              wen_b,
    input  logic [ADDR_W-1:0] wn_b,
    input  logic [DATA_W-1:0] wd_b,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              sb_flush,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]         r_mem [DEPTH];
    wsel_e                     w_wsel [DEPTH];
    logic [DEPTH-1:0]          w_pend;
    logic [1:0][ADDR_W-1:0]    w_rn;
    logic [1:0][DATA_W-1:0]    w_rd;
    logic [1:0]                w_busy;

    reg_scoreboard #(
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wen_a    (wen_a),
        .wn_a     (wn_a),
        .wen_b    (wen_b),
        .wn_b     (wn_b),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .sb_flush (sb_flush),
        .pend     (w_pend),
        .pend_cnt (pend_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wsel
            if (ZERO_R0 != 0 && gi == 0) begin : g_zero
                assign w_wsel[gi] = WSEL_NONE;
            end else begin : g_live
                assign w_wsel[gi] = wsel_pick(wen_a && (wn_a == ADDR_W'(gi)),
                                              wen_b && (wn_b == ADDR_W'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                case (w_wsel[i])
                    WSEL_A:  r_mem[i] <= wd_a;
                    WSEL_B:  r_mem[i] <= wd_b;
                    default: ;
                endcase
            end
        end
    end

    assign w_rn[0] = rn1;
    assign w_rn[1] = rn2;

    // A write landing this cycle satisfies the pending mark only when it is forwarded.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            wsel_e w_rsel;
            logic  w_zero;
            assign w_zero = (ZERO_R0 != 0) && (w_rn[gi] == '0);
            assign w_rsel = wsel_pick(wen_a && (wn_a == w_rn[gi]),
                                      wen_b && (wn_b == w_rn[gi]));
            assign w_rd[gi] = w_zero                                 ? '0   :
                              (BYPASS != 0 && w_rsel == WSEL_B)      ? wd_b :
                              (BYPASS != 0 && w_rsel == WSEL_A)      ? wd_a :
                                                                       r_mem[w_rn[gi]];
            assign w_busy[gi] = w_pend[w_rn[gi]] && !w_zero &&
                                ((BYPASS == 0) || (w_rsel == WSEL_NONE));
        end
    endgenerate

    assign rd1   = w_rd[0];
    assign rd2   = w_rd[1];
    assign busy1 = w_busy[0];
    assign busy2 = w_busy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a forwarding instance and a non-forwarding
// instance share every input so both read behaviours are checked side by side.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  rn1, rn2, wn_a, wn_b, sb_addr;
    logic [31:0] wd_a, wd_b;
    logic        wen_a, wen_b, sb_set, sb_flush;

    logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
    logic        busy1, busy2, busy1_nb, busy2_nb;
    logic [4:0]  pend_cnt, pend_cnt_nb;

    int n_tests = 0;
    int n_fail  = 0;

    reg_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rn1(rn1), .rn2(rn2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2),
        .wen_a(wen_a), .wn_a(wn_a), .wd_a(wd_a),
        .wen_b(wen_b), .wn_b(wn_b), .wd_b(wd_b),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush),
        .pend_cnt(pend_cnt)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_R0(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rn1(rn1), .rn2(rn2), .rd1(rd1_nb), .rd2(rd2_nb),
        .busy1(busy1_nb), .busy2(busy2_nb),
        .wen_a(wen_a), .wn_a(wn_a), .wd_a(wd_a),
        .wen_b(wen_b), .wn_b(wn_b), .wd_b(wd_b),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_flush(sb_flush),
        .pend_cnt(pend_cnt_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen_a = 0; wn_a = 0; wd_a = 0;
        wen_b = 0; wn_b = 0; wd_b = 0;
        sb_set = 0; sb_addr = 0; sb_flush = 0;
    endtask

    task automatic test_reset();
        idle(); rn1 = 0; rn2 = 0; rst = 0;
        #2 rst = 1;
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            rn1 = 4'(i); rn2 = 4'(15 - i);
            #1;
            n_tests++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rd idx %0d: got rd1=%h rd2=%h expected 00000000", i, rd1, rd2);
            end
        end
        n_tests++;
        if (pend_cnt !== 5'd0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sb: got pend_cnt=%0d busy1=%b busy2=%b expected 0 0 0", pend_cnt, busy1, busy2);
        end
        $display("[TB] reset: 16 indices read");
    endtask

    task automatic test_bypass();
        tick();
        wen_a = 1; wn_a = 5; wd_a = 32'h000BACC1; rn1 = 5;
        #1;
        n_tests++;
        if (rd1 !== 32'h000BACC1) begin
            n_fail++; $display("FAIL bypass_fwd: got %h expected 000bacc1", rd1);
        end
        n_tests++;
        if (rd1_nb !== 32'h0) begin
            n_fail++; $display("FAIL bypass_off_same_cycle: got %h expected 00000000", rd1_nb);
        end
        tick(); idle(); #1;
        n_tests++;
        if (rd1 !== 32'h000BACC1 || rd1_nb !== 32'h000BACC1) begin
            n_fail++; $display("FAIL bypass_stored: got %h/%h expected 000bacc1", rd1, rd1_nb);
        end
        $display("[TB] bypass: write r5=000bacc1");
    endtask

    task automatic test_port_priority();
        tick();
        wen_a = 1; wn_a = 3; wd_a = 32'h11;
        wen_b = 1; wn_b = 3; wd_b = 32'h22;
        rn1 = 3;
        #1;
        n_tests++;
        if (rd1 !== 32'h22) begin
            n_fail++; $display("FAIL prio_fwd: got %h expected 00000022", rd1);
        end
        tick(); idle(); #1;
        n_tests++;
        if (rd1 !== 32'h22 || rd1_nb !== 32'h22) begin
            n_fail++; $display("FAIL prio_stored: got %h/%h expected 00000022", rd1, rd1_nb);
        end
        $display("[TB] port priority: r3 A=11 B=22");
    endtask

    task automatic test_scoreboard();
        tick();
        sb_set = 1; sb_addr = 7;
        tick(); idle(); rn2 = 7; #1;
        n_tests++;
        if (busy2 !== 1'b1 || busy2_nb !== 1'b1 || pend_cnt !== 5'd1) begin
            n_fail++;
            $display("FAIL sb_pending: got busy2=%b/%b pend_cnt=%0d expected 1/1 1", busy2, busy2_nb, pend_cnt);
        end
        wen_b = 1; wn_b = 7; wd_b = 32'h101ED; #1;
        n_tests++;
        if (busy2 !== 1'b0 || busy2_nb !== 1'b1 || rd2 !== 32'h101ED) begin
            n_fail++;
            $display("FAIL sb_writeback: got busy2=%b/%b rd2=%h expected 0/1 000101ed", busy2, busy2_nb, rd2);
        end
        tick(); idle(); #1;
        n_tests++;
        if (pend_cnt !== 5'd0 || busy2 !== 1'b0 || rd2_nb !== 32'h101ED) begin
            n_fail++;
            $display("FAIL sb_cleared: got pend_cnt=%0d busy2=%b rd2=%h expected 0 0 000101ed", pend_cnt, busy2, rd2_nb);
        end
        $display("[TB] scoreboard: r7 set then written back");
    endtask

    task automatic test_flush();
        tick();
        sb_set = 1; sb_addr = 1; tick();
        sb_addr = 2; tick();
        sb_addr = 4; tick();
        idle(); #1;
        n_tests++;
        if (pend_cnt !== 5'd3) begin
            n_fail++; $display("FAIL flush_pre: got pend_cnt=%0d expected 3", pend_cnt);
        end
        sb_flush = 1; sb_set = 1; sb_addr = 5;
        tick(); idle(); rn1 = 5; rn2 = 2; #1;
        n_tests++;
        if (pend_cnt !== 5'd0 || busy1 !== 1'b0 || busy2 !== 1'b0 || pend_cnt_nb !== 5'd0) begin
            n_fail++;
            $display("FAIL flush: got pend_cnt=%0d busy1=%b busy2=%b expected 0 0 0", pend_cnt, busy1, busy2);
        end
        $display("[TB] flush: r1,r2,r4 set, flush with set r5");
    endtask

    task automatic test_set_and_write();
        tick();
        sb_set = 1; sb_addr = 6; wen_a = 1; wn_a = 6; wd_a = 32'h66;
        tick(); idle(); rn1 = 6; #1;
        n_tests++;
        if (pend_cnt !== 5'd1 || busy1 !== 1'b1 || rd1 !== 32'h66) begin
            n_fail++;
            $display("FAIL set_beats_clear: got pend_cnt=%0d busy1=%b rd1=%h expected 1 1 00000066", pend_cnt, busy1, rd1);
        end
        sb_flush = 1; tick(); idle();
        $display("[TB] set+write same cycle: r6");
    endtask

    task automatic test_pend_full();
        tick();
        for (int i = 0; i < 16; i++) begin
            sb_set = 1; sb_addr = 4'(i); tick();
        end
        idle(); #1;
        n_tests++;
        if (pend_cnt !== 5'd15) begin
            n_fail++; $display("FAIL pend_full: got pend_cnt=%0d expected 15", pend_cnt);
        end
        sb_flush = 1; tick(); idle();
        $display("[TB] pend full: set all 16 indices");
    endtask

    task automatic test_zero_r0();
        tick();
        wen_a = 1; wn_a = 0; wd_a = 32'hFFFFFFFF; sb_set = 1; sb_addr = 0; rn1 = 0; #1;
        n_tests++;
        if (rd1 !== 32'h0 || busy1 !== 1'b0) begin
            n_fail++; $display("FAIL r0_same_cycle: got rd1=%h busy1=%b expected 00000000 0", rd1, busy1);
        end
        tick(); idle(); #1;
        n_tests++;
        if (rd1 !== 32'h0 || rd1_nb !== 32'h0 || busy1 !== 1'b0 || pend_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL r0_after: got rd1=%h/%h busy1=%b pend_cnt=%0d expected 0 0 0 0", rd1, rd1_nb, busy1, pend_cnt);
        end
        $display("[TB] zero r0: write ffffffff and set r0");
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_val [4];
        exp_val[0] = 32'h1001; exp_val[1] = 32'h2002; exp_val[2] = 32'h3003; exp_val[3] = 32'h4004;
        tick();
        for (int i = 0; i < 4; i++) begin
            idle();
            if (i % 2 == 0) begin wen_a = 1; wn_a = 4'(8 + i); wd_a = exp_val[i]; end
            else            begin wen_b = 1; wn_b = 4'(8 + i); wd_b = exp_val[i]; end
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rn1 = 4'(8 + i); rn2 = 4'(11 - i); #1;
            n_tests++;
            if (rd1 !== exp_val[i] || rd2 !== exp_val[3 - i]) begin
                n_fail++;
                $display("FAIL b2b idx %0d: got rd1=%h rd2=%h expected %h %h", i, rd1, rd2, exp_val[i], exp_val[3 - i]);
            end
        end
        $display("[TB] back to back: r8..r11 alternating ports");
    endtask

    task automatic test_async_reset();
        tick();
        wen_a = 1; wn_a = 9; wd_a = 32'hA5; sb_set = 1; sb_addr = 9;
        tick(); idle(); rn1 = 9; #1;
        n_tests++;
        if (rd1 !== 32'hA5 || pend_cnt !== 5'd1 || busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got rd1=%h pend_cnt=%0d busy1=%b expected 000000a5 1 1", rd1, pend_cnt, busy1);
        end
        wen_a = 1; wn_a = 10; wd_a = 32'h77; sb_set = 1; sb_addr = 10;
        rst = 1; #1;
        n_tests++;
        if (rd1 !== 32'h0 || pend_cnt !== 5'd0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_async: got rd1=%h pend_cnt=%0d busy1=%b expected 0 0 0", rd1, pend_cnt, busy1);
        end
        tick();
        idle(); rn1 = 10; rst = 0; #1;
        n_tests++;
        if (rd1 !== 32'h0 || pend_cnt !== 5'd0 || rd1_nb !== 32'h0) begin
            n_fail++;
            $display("FAIL arst_blocked: got rd1=%h pend_cnt=%0d expected 0 0", rd1, pend_cnt);
        end
        $display("[TB] async reset: mid-sequence");
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_port_priority();
        test_scoreboard();
        test_flush();
        test_set_and_write();
        test_pend_full();
        test_zero_r0();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter ADDR_W, 4, register index width; DEPTH = 2**ADDR_W.
REQ-003 Parameter ZERO_R0, 1, when 1 register 0 reads 0 and ignores writes.
REQ-004 Parameter BYPASS, 1, when 1 same-cycle write data forwards to read ports.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rn1, rn2  input  ADDR_W  read-port indices.
REQ-008 rd1, rd2  output  DATA_W  read data, combinational.
REQ-009 busy1, busy2  output  1  indexed register has a pending write not satisfied this cycle.
REQ-010 wen_a, wn_a, wd_a  input  1/ADDR_W/DATA_W  write port A (writeback).
REQ-011 wen_b, wn_b, wd_b  input  1/ADDR_W/DATA_W  write port B (load return).
REQ-012 sb_set, sb_addr  input  1/ADDR_W  mark register pending (issue of an instruction writing sb_addr).
REQ-013 sb_flush  input  1  clear all pending marks (pipeline flush).
REQ-014 pend_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-015 A write from port A or B SHALL update the array on the rising clk edge when its enable is high.
REQ-016 wen_a and wen_b to the same index SHALL resolve with port B winning; port A data discarded.
REQ-017 With ZERO_R0=1, writes to index 0 SHALL be dropped and rd1/rd2 for index 0 SHALL be 0; sb_set to index 0 SHALL be ignored.
REQ-018 With BYPASS=1, a read whose index matches an enabled write in the same cycle SHALL return that write data (port B before A); with BYPASS=0 it SHALL return the stored value.
REQ-019 Scoreboard: one pending bit per register; sb_set SHALL set bit sb_addr at the next edge.
REQ-020 An enabled write to index i SHALL clear pending bit i at the next edge.
REQ-021 sb_set and a write to the same index in the same cycle SHALL leave the bit set (new issue wins).
REQ-022 sb_flush SHALL clear all pending bits at the next edge and SHALL take priority over sb_set in that cycle.
REQ-023 busyN SHALL be high iff pending bit rnN is set and (BYPASS=0 or no enabled write to rnN this cycle); always low for index 0 when ZERO_R0=1.
REQ-024 pend_cnt SHALL equal the population count of the registered pending bits; range 0..DEPTH, never wraps.
REQ-025 Read latency SHALL be zero cycles; write-to-stored-read latency one edge.

Reset
REQ-026 rst high SHALL immediately clear all registers to 0 and all pending bits to 0; pend_cnt = 0, busy1 = busy2 = 0.
REQ-027 Writes and sb_set asserted while rst is high SHALL have no effect; first effective edge is the first rising clk with rst low.
REQ-028 rst asserted mid-operation SHALL discard pending marks and in-flight writes without glitch ordering dependence.

Structure
REQ-029 DATA_W/ADDR_W defaults and the write-port-select encoding SHALL live in shared package reg_file_pkg.
REQ-030 The pending-bit array, set/clear/flush logic and pend_cnt SHALL be a sub-module reg_scoreboard; the data array and bypass muxes stay in reg_file_sb.

Verification
REQ-031 Reset then read all 16 indices -> all rd = 0x00000000, pend_cnt = 0.
REQ-032 wen_a, wn_a=5, wd_a=0x000BACC1, rn1=5 same cycle -> rd1=0x000BACC1 (BYPASS=1), stored value 0 (BYPASS=0); next cycle rd1=0x000BACC1 both.
REQ-033 wen_a wn_a=3 wd_a=0x11, wen_b wn_b=3 wd_b=0x22 -> r3 = 0x22.
REQ-034 sb_set r7; next cycle rn2=7 -> busy2=1, pend_cnt=1; wen_b wn_b=7 wd_b=0x101ED -> busy2=0 that cycle (BYPASS=1), rd2=0x101ED, pend_cnt=0 next.
REQ-035 sb_set on r1,r2,r4 over three cycles then sb_flush with sb_set r5 -> pend_cnt=0, no bits set.
REQ-036 wen_a wn_a=0 wd_a=0xFFFFFFFF, sb_set r0 (ZERO_R0=1) -> rd1 for rn1=0 stays 0, busy1=0, pend_cnt=0; rst pulsed mid-sequence -> all state 0 asynchronously.
